mem_stage_async: RTL and testbench
==================================

Name: mem_stage_async

Overview:
- Next-generation MEM pipeline stage for the MIPS core.
- Sits between EX and WB and talks to a split-transaction, SRAM-like data bus (request issued in EX; data_ok/rdata returned here with variable latency).
- Holds the instruction until its load data returns, and buffers returned data while WB back-pressures.
- Discards responses that belong to requests cancelled by an exception/eret flush.
- Performs byte-lane load extraction; the sideband payload is parametrised.

Parameters:
SIDE_WD, 120, width of opaque passthrough payload (pc, dest, gr_we, exception fields, cp0 info); carried unchanged from EX to WB.
CNT_W, 2, width of outstanding-discard counter (max 2^CNT_W-1 cancelled requests).
LWLR_EN, 1, 1 = LWL/LWR merge supported; 0 = those ops behave as LW.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
es_to_ms_valid  in  1  EX holds a valid instruction for MEM
ms_allowin  out  1  MEM accepts an instruction this cycle
es_req_sent  in  1  incoming instruction issued a data-bus request (addr_ok seen)
es_mem_op  in  7  one-hot {lwl,lwr,lw,lbu,lb,lhu,lh}; all zero = non-load
es_result  in  32  ALU result / address; [1:0] selects the byte lane
es_rt_value  in  32  old rt value for LWL/LWR merge
es_side  in  SIDE_WD  passthrough payload
es_cancel_req  in  1  EX is dropping an already-issued request because of flush
flush  in  1  exception/eret flush from WB
data_sram_data_ok  in  1  response strobe, responses in request order
data_sram_rdata  in  32  response data
ws_allowin  in  1  WB accepts
ms_to_ws_valid  out  1  valid to WB
ms_final_result  out  32  load result if load, else es_result
ms_side  out  SIDE_WD  registered payload
ms_fw_block  out  1  MEM holds a load whose data is not yet available (ID must stall, not forward)
ms_discard_busy  out  1  discard counter nonzero

Behaviour:
- Reset (resetn=0 at posedge): ms_valid=0, buf_valid=0, discard_cnt=0, payload registers don't-care. Outputs: ms_to_ws_valid=0, ms_fw_block=0, ms_discard_busy=0, ms_allowin=1.
- Capture: on es_to_ms_valid && ms_allowin && !flush, latch op, result, rt, side, and need_data=es_req_sent&&|es_mem_op. Clear buf_valid at the same time.
- Effective response: resp_ok = data_ok && discard_cnt==0. When discard_cnt>0, data_ok is consumed by the discard and decrements the counter.
- ready_go = !need_data || buf_valid || (resp_ok && ms_valid && need_data). Same-cycle data_ok feeds ms_final_result directly (zero added latency).
- ms_allowin = !ms_valid || (ready_go && ws_allowin). ms_to_ws_valid = ms_valid && ready_go && !flush.
- Buffering: resp_ok while ms_valid && need_data && !buf_valid && !ws_allowin → store rdata in buf, set buf_valid. Buffer holds until the instruction leaves.
- data_ok with discard_cnt==0 and no waiting load is illegal; the bench must assert it never occurs.
- Flush:
  - ms_valid<=0 next cycle.
  - If ms_valid && need_data && !buf_valid && !resp_ok, that request is orphaned: +1 to discard_cnt.
  - es_cancel_req adds +1.
  - Net update = incs − (data_ok && discard_cnt>0). Up to two increments plus one decrement in one cycle.
  - Overflow beyond 2^CNT_W-1 is illegal and must be asserted.
- Flush has priority over capture; no capture on a flush cycle.
- ms_fw_block = ms_valid && need_data && !ready_go.
- Load extraction, by addr[1:0] and data d:
  - LB/LBU: byte addr; LH/LHU: halfword at 0 or 2; sign- or zero-extend as appropriate.
  - LW: d.
  - LWL off k: {d[8k+7:0], rt[23-8k:0]}; k=3 → d.
  - LWR off k: {rt[31:32-8k], d[31:8k]}; k=0 → d.
  - LWLR_EN=0: LWL/LWR → d.
- Mid-operation reset clears the counter and buffer; in-flight bus responses are the bus's responsibility after reset.

Test Plan:
- Non-load ADDU result 0x1234, ws_allowin=1 → ms_to_ws_valid the cycle after capture, ms_final_result=0x1234, ms_fw_block=0.
- LB addr low 2'b11, data_ok 3 cycles later with rdata 0x80AABBCC → ms_fw_block=1 for 3 cycles, then result 0xFFFFFF80 and valid the same cycle as data_ok.
- LHU addr 2'b10, data_ok with ws_allowin=0 for 2 cycles, rdata 0xBEEF0001 → buf_valid=1; after ws_allowin rises, result 0x0000BEEF; later data_ok toggles do not change it.
- Load pending plus es_cancel_req with flush → discard_cnt=2. Next two data_ok are swallowed (discard_busy falls after the second). A new LW then receives the third data_ok, rdata 0xDEADBEEF.
- LWL addr 2'b01, rt=0x11223344, rdata 0xAABBCCDD → 0xCCDD3344. LWR addr 2'b10, same values → 0x1122AABB. With LWLR_EN=0, both give 0xAABBCCDD.
- resetn=0 while discard_cnt=1 and buf_valid=1 → all cleared next cycle, ms_allowin=1, ms_to_ws_valid=0.

Source files
------------

// File: rtl/mem_stage_async.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | mem_stage_async: MIPS MEM stage for a split-transaction data bus with a    |
// | response buffer, flush-orphan discard counter and load lane extraction.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_stage_async #(
  parameter int SIDE_WD = 120,
  parameter int CNT_W   = 2,
  parameter bit LWLR_EN = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               es_to_ms_valid,
  output logic               ms_allowin,
  input  logic               es_req_sent,
  input  logic [6:0]         es_mem_op,
  input  logic [31:0]        es_result,
  input  logic [31:0]        es_rt_value,
  input  logic [SIDE_WD-1:0] es_side,
  input  logic               es_cancel_req,
  input  logic               flush,
  input  logic               data_sram_data_ok,
  input  logic [31:0]        data_sram_rdata,
  input  logic               ws_allowin,
  output logic               ms_to_ws_valid,
  output logic [31:0]        ms_final_result,
  output logic [SIDE_WD-1:0] ms_side,
  output logic               ms_fw_block,
  output logic               ms_discard_busy
);

  logic               ms_valid_q, ms_valid_d;
  logic               buf_valid_q, buf_valid_d;
  logic               need_data_q, need_data_d;
  logic [CNT_W-1:0]   discard_cnt_q, discard_cnt_d;
  logic [6:0]         op_q, op_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        rt_q, rt_d;
  logic [31:0]        buf_q, buf_d;
  logic [SIDE_WD-1:0] side_q, side_d;

  logic        resp_ok;
  logic        ready_go;
  logic        capture;
  logic        orphan_inc;
  logic        discard_dec;
  logic [31:0] load_data;
  logic [1:0]  addr_off;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_res;
  logic [31:0] lwr_res;
  logic [31:0] load_value;

  // While orphans are outstanding, every data_ok belongs to a cancelled request.
  assign resp_ok     = data_sram_data_ok && (discard_cnt_q == '0);
  assign discard_dec = data_sram_data_ok && (discard_cnt_q != '0);
  assign ready_go    = !need_data_q || buf_valid_q || (resp_ok && ms_valid_q && need_data_q);
  assign ms_allowin  = !ms_valid_q || (ready_go && ws_allowin);
  assign capture     = es_to_ms_valid && ms_allowin && !flush;
  assign orphan_inc  = flush && ms_valid_q && need_data_q && !buf_valid_q && !resp_ok;

  assign ms_to_ws_valid  = ms_valid_q && ready_go && !flush;
  assign ms_fw_block     = ms_valid_q && need_data_q && !ready_go;
  assign ms_discard_busy = (discard_cnt_q != '0);
  assign ms_side         = side_q;

  always_comb begin
    ms_valid_d  = ms_valid_q;
    buf_valid_d = buf_valid_q;
    need_data_d = need_data_q;
    op_d        = op_q;
    result_d    = result_q;
    rt_d        = rt_q;
    buf_d       = buf_q;
    side_d      = side_q;

    if (flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end

    if (capture) begin
      need_data_d = es_req_sent && (|es_mem_op);
      op_d        = es_mem_op;
      result_d    = es_result;
      rt_d        = es_rt_value;
      side_d      = es_side;
    end

    // The buffer only matters while its instruction is still parked here.
    if (flush || ms_allowin) begin
      buf_valid_d = 1'b0;
    end else if (resp_ok && ms_valid_q && need_data_q && !buf_valid_q && !ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_d       = data_sram_rdata;
    end

    discard_cnt_d = discard_cnt_q + CNT_W'(orphan_inc) + CNT_W'(es_cancel_req)
                  - CNT_W'(discard_dec);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      buf_valid_q   <= 1'b0;
      need_data_q   <= 1'b0;
      discard_cnt_q <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      buf_valid_q   <= buf_valid_d;
      need_data_q   <= need_data_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q     <= op_d;
    result_q <= result_d;
    rt_q     <= rt_d;
    buf_q    <= buf_d;
    side_q   <= side_d;
  end

  assign load_data = buf_valid_q ? buf_q : data_sram_rdata;
  assign addr_off  = result_q[1:0];
  assign half_sel  = addr_off[1] ? load_data[31:16] : load_data[15:0];

  always_comb begin
    case (addr_off)
      2'd0:    byte_sel = load_data[7:0];
      2'd1:    byte_sel = load_data[15:8];
      2'd2:    byte_sel = load_data[23:16];
      default: byte_sel = load_data[31:24];
    endcase
  end

  generate
    if (LWLR_EN) begin : g_lwlr
      always_comb begin
        case (addr_off)
          2'd0: begin
            lwl_res = {load_data[7:0], rt_q[23:0]};
            lwr_res = load_data;
          end
          2'd1: begin
            lwl_res = {load_data[15:0], rt_q[15:0]};
            lwr_res = {rt_q[31:24], load_data[31:8]};
          end
          2'd2: begin
            lwl_res = {load_data[23:0], rt_q[7:0]};
            lwr_res = {rt_q[31:16], load_data[31:16]};
          end
          default: begin
            lwl_res = load_data;
            lwr_res = {rt_q[31:8], load_data[31:24]};
          end
        endcase
      end
    end else begin : g_no_lwlr
      assign lwl_res = load_data;
      assign lwr_res = load_data;
    end
  endgenerate

  always_comb begin
    load_value = load_data;
    if (op_q[6]) begin
      load_value = lwl_res;
    end else if (op_q[5]) begin
      load_value = lwr_res;
    end else if (op_q[3]) begin
      load_value = {24'd0, byte_sel};
    end else if (op_q[2]) begin
      load_value = {{24{byte_sel[7]}}, byte_sel};
    end else if (op_q[1]) begin
      load_value = {16'd0, half_sel};
    end else if (op_q[0]) begin
      load_value = {{16{half_sel[15]}}, half_sel};
    end
    ms_final_result = (|op_q) ? load_value : result_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_async.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_mem_stage_async: directed plus random bench for mem_stage_async.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_stage_async;
  localparam int SIDE_WD  = 120;
  localparam int CNT_W    = 2;
  localparam int MAX_DISC = 3;

  localparam logic [6:0] OP_LWL = 7'b1000000;
  localparam logic [6:0] OP_LWR = 7'b0100000;
  localparam logic [6:0] OP_LW  = 7'b0010000;
  localparam logic [6:0] OP_LB  = 7'b0000100;
  localparam logic [6:0] OP_LHU = 7'b0000010;
  localparam logic [6:0] OP_LH  = 7'b0000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               resetn, es_to_ms_valid, es_req_sent, es_cancel_req, flush;
  logic               data_sram_data_ok, ws_allowin;
  logic [6:0]         es_mem_op;
  logic [31:0]        es_result, es_rt_value, data_sram_rdata;
  logic [SIDE_WD-1:0] es_side;

  logic               a_allowin, a_valid, a_fw, a_busy;
  logic [31:0]        a_result;
  logic [SIDE_WD-1:0] a_side;
  logic               b_allowin, b_valid, b_fw, b_busy;
  logic [31:0]        b_result;
  logic [SIDE_WD-1:0] b_side;

  mem_stage_async #(.SIDE_WD(SIDE_WD), .CNT_W(CNT_W), .LWLR_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(a_allowin),
    .es_req_sent(es_req_sent), .es_mem_op(es_mem_op), .es_result(es_result),
    .es_rt_value(es_rt_value), .es_side(es_side), .es_cancel_req(es_cancel_req),
    .flush(flush), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(a_valid), .ms_final_result(a_result),
    .ms_side(a_side), .ms_fw_block(a_fw), .ms_discard_busy(a_busy));

  mem_stage_async #(.SIDE_WD(SIDE_WD), .CNT_W(CNT_W), .LWLR_EN(1'b0)) dut_nolr (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(b_allowin),
    .es_req_sent(es_req_sent), .es_mem_op(es_mem_op), .es_result(es_result),
    .es_rt_value(es_rt_value), .es_side(es_side), .es_cancel_req(es_cancel_req),
    .flush(flush), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .ms_to_ws_valid(b_valid), .ms_final_result(b_result),
    .ms_side(b_side), .ms_fw_block(b_fw), .ms_discard_busy(b_busy));

  int tests = 0;
  int fails = 0;

  // Instruction-level model: what MEM holds, whether its data has come back, and
  // how many bus responses are still owed to cancelled requests.
  bit                 m_valid, m_need, m_have;
  logic [6:0]         m_op;
  logic [31:0]        m_res, m_rt, m_data;
  logic [SIDE_WD-1:0] m_side;
  int                 m_disc;
  bit                 s_resp, s_avail, s_allow;

  task automatic chk_core(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk_core(tag, {127'd0, obs}, {127'd0, exp});
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_core(tag, {96'd0, obs}, {96'd0, exp});
  endtask

  task automatic chkside(input string tag, input logic [SIDE_WD-1:0] obs, input logic [SIDE_WD-1:0] exp);
    chk_core(tag, {8'd0, obs}, {8'd0, exp});
  endtask

  function automatic logic [31:0] ref_load(input logic [6:0] op, input logic [1:0] k,
                                           input logic [31:0] rt, input logic [31:0] d,
                                           input bit lwlr);
    logic [31:0] b, h;
    b = (d >> (8 * k)) & 32'hFF;
    h = (d >> (16 * (k / 2))) & 32'hFFFF;
    if (op[6]) return lwlr ? ((d << (8 * (3 - k))) | (rt & ((32'h1 << (8 * (3 - k))) - 32'h1))) : d;
    if (op[5]) return lwlr ? ((d >> (8 * k)) | (rt & ~(32'hFFFF_FFFF >> (8 * k)))) : d;
    if (op[4]) return d;
    if (op[3]) return b;
    if (op[2]) return (b ^ 32'h80) - 32'h80;
    if (op[1]) return h;
    if (op[0]) return (h ^ 32'h8000) - 32'h8000;
    return d;
  endfunction

  task automatic settle_and_check();
    bit          waiting, exp_valid;
    logic [31:0] d;
    #1;
    waiting = m_valid && m_need && !m_have;
    s_resp  = data_sram_data_ok && (m_disc == 0);
    tests++;
    assert (!(data_sram_data_ok && m_disc == 0 && !waiting)) else begin
      fails++;
      $error("FAIL bus_data_ok_unowned: observed data_ok=1 expected no unowned response");
    end
    s_avail   = !m_need || m_have || (s_resp && m_valid && m_need);
    s_allow   = !m_valid || (s_avail && ws_allowin);
    exp_valid = m_valid && s_avail && !flush;
    chk1("to_ws_valid", a_valid, exp_valid);
    chk1("allowin", a_allowin, s_allow);
    chk1("fw_block", a_fw, m_valid && m_need && !s_avail);
    chk1("discard_busy", a_busy, m_disc != 0);
    chk1("nolr_to_ws_valid", b_valid, exp_valid);
    chk1("nolr_allowin", b_allowin, s_allow);
    if (exp_valid) begin
      d = m_have ? m_data : data_sram_rdata;
      chk32("final_result", a_result, (m_op == '0) ? m_res : ref_load(m_op, m_res[1:0], m_rt, d, 1'b1));
      chk32("nolr_final_result", b_result, (m_op == '0) ? m_res : ref_load(m_op, m_res[1:0], m_rt, d, 1'b0));
      chkside("side", a_side, m_side);
    end
  endtask

  task automatic advance();
    bit dec, orphan;
    if (!resetn) begin
      m_valid = 1'b0;
      m_have  = 1'b0;
      m_disc  = 0;
    end else begin
      dec    = data_sram_data_ok && (m_disc > 0);
      orphan = flush && m_valid && m_need && !m_have && !s_resp;
      m_disc = m_disc + int'(orphan) + int'(es_cancel_req) - int'(dec);
      if (flush) begin
        m_valid = 1'b0;
      end else if (s_allow) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) begin
          m_need = es_req_sent && (es_mem_op != '0);
          m_have = 1'b0;
          m_op   = es_mem_op;
          m_res  = es_result;
          m_rt   = es_rt_value;
          m_side = es_side;
        end
      end else if (s_resp && m_valid && m_need && !m_have) begin
        m_have = 1'b1;
        m_data = data_sram_rdata;
      end
      tests++;
      assert (m_disc <= MAX_DISC) else begin
        fails++;
        $error("FAIL discard_overflow: observed %0d expected <= %0d", m_disc, MAX_DISC);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    settle_and_check();
    advance();
  endtask

  task automatic idle();
    es_to_ms_valid    = 1'b0;
    es_req_sent       = 1'b0;
    es_mem_op         = '0;
    es_cancel_req     = 1'b0;
    flush             = 1'b0;
    data_sram_data_ok = 1'b0;
    ws_allowin        = 1'b1;
    data_sram_rdata   = $urandom;
  endtask

  task automatic send(input logic [6:0] op, input logic [31:0] res, input logic [31:0] rt);
    es_to_ms_valid = 1'b1;
    es_mem_op      = op;
    es_req_sent    = (op != '0);
    es_result      = res;
    es_rt_value    = rt;
    for (int i = 0; i < SIDE_WD; i++) es_side[i] = 1'($urandom);
  endtask

  initial begin
    int idx;
    bit waiting;
    m_valid = 1'b0; m_need = 1'b0; m_have = 1'b0; m_disc = 0;
    m_op = '0; m_res = '0; m_rt = '0; m_data = '0; m_side = '0;
    s_resp = 1'b0; s_avail = 1'b0; s_allow = 1'b1;
    es_result = '0; es_rt_value = '0; es_side = '0;
    idle();
    resetn = 1'b0;
    @(negedge clk);
    advance();
    advance();
    resetn = 1'b1;

    // Reset state
    idle(); settle_and_check();
    chk1("rst_allowin", a_allowin, 1'b1);
    chk1("rst_valid", a_valid, 1'b0);
    chk1("rst_fw", a_fw, 1'b0);
    chk1("rst_busy", a_busy, 1'b0);
    advance();

    // Non-load passes straight through
    idle(); send(7'd0, 32'h0000_1234, 32'd0); tick();
    idle(); settle_and_check();
    chk1("addu_valid", a_valid, 1'b1);
    chk32("addu_result", a_result, 32'h0000_1234);
    chk1("addu_fw", a_fw, 1'b0);
    advance();

    // LB at byte 3, three-cycle latency, zero-latency bypass on data_ok
    idle(); send(OP_LB, 32'h0000_1003, 32'd0); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); settle_and_check();
      chk1("lb_fw_wait", a_fw, 1'b1);
      chk1("lb_valid_wait", a_valid, 1'b0);
      advance();
    end
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80AA_BBCC; settle_and_check();
    chk1("lb_valid", a_valid, 1'b1);
    chk32("lb_result", a_result, 32'hFFFF_FF80);
    advance();

    // LHU buffered under WB back-pressure
    idle(); send(OP_LHU, 32'h0000_2002, 32'd0); tick();
    idle(); ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_0001; tick();
    idle(); ws_allowin = 1'b0; settle_and_check();
    chk32("lhu_buffered", a_result, 32'h0000_BEEF);
    advance();
    idle(); ws_allowin = 1'b1; data_sram_rdata = 32'h1234_5678; settle_and_check();
    chk1("lhu_valid", a_valid, 1'b1);
    chk32("lhu_result", a_result, 32'h0000_BEEF);
    advance();

    // Flush with a pending load plus a cancelled EX request: two responses swallowed
    idle(); send(OP_LW, 32'h0000_3000, 32'd0); tick();
    idle(); flush = 1'b1; es_cancel_req = 1'b1; settle_and_check();
    chk1("flush_valid", a_valid, 1'b0);
    advance();
    idle(); settle_and_check(); chk1("disc_busy_2", a_busy, 1'b1); advance();
    idle(); data_sram_data_ok = 1'b1; settle_and_check(); chk1("disc_busy_1", a_busy, 1'b1); advance();
    idle(); send(OP_LW, 32'h0000_4000, 32'd0); data_sram_data_ok = 1'b1; tick();
    idle(); settle_and_check();
    chk1("disc_busy_0", a_busy, 1'b0);
    chk1("disc_new_fw", a_fw, 1'b1);
    advance();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF; settle_and_check();
    chk32("disc_new_lw", a_result, 32'hDEAD_BEEF);
    advance();

    // LWL / LWR merge, and the plain-LW behaviour when merging is disabled
    idle(); send(OP_LWL, 32'h0000_5001, 32'h1122_3344); tick();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABB_CCDD; settle_and_check();
    chk32("lwl_result", a_result, 32'hCCDD_3344);
    chk32("lwl_nolr_result", b_result, 32'hAABB_CCDD);
    advance();
    idle(); send(OP_LWR, 32'h0000_5002, 32'h1122_3344); tick();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAABB_CCDD; settle_and_check();
    chk32("lwr_result", a_result, 32'h1122_AABB);
    chk32("lwr_nolr_result", b_result, 32'hAABB_CCDD);
    advance();

    // Reset while a discard is owed and the buffer is full
    idle(); send(OP_LH, 32'h0000_6000, 32'd0); tick();
    idle(); ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_8001; tick();
    idle(); ws_allowin = 1'b0; es_cancel_req = 1'b1; settle_and_check();
    chk32("lh_buffered", a_result, 32'hFFFF_8001);
    advance();
    idle(); ws_allowin = 1'b0; settle_and_check(); chk1("pre_rst_busy", a_busy, 1'b1); advance();
    idle(); ws_allowin = 1'b0; resetn = 1'b0; tick();
    resetn = 1'b1;
    idle(); settle_and_check();
    chk1("post_rst_allowin", a_allowin, 1'b1);
    chk1("post_rst_valid", a_valid, 1'b0);
    chk1("post_rst_busy", a_busy, 1'b0);
    advance();
    idle(); send(OP_LW, 32'h0000_7000, 32'd0); tick();
    idle(); data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D; settle_and_check();
    chk32("post_rst_lw", a_result, 32'hCAFE_F00D);
    advance();

    // Random traffic against the model
    for (int cyc = 0; cyc < 2000; cyc++) begin
      idle();
      es_to_ms_valid = ($urandom_range(0, 9) < 7);
      idx = int'($urandom_range(0, 7));
      es_mem_op = '0;
      if (idx < 7) es_mem_op[idx] = 1'b1;
      es_req_sent = (es_mem_op != '0);
      es_result   = $urandom;
      es_rt_value = $urandom;
      for (int i = 0; i < SIDE_WD; i++) es_side[i] = 1'($urandom);
      flush         = (m_disc <= 1) && ($urandom_range(0, 11) == 0);
      es_cancel_req = flush && ($urandom_range(0, 1) == 1);
      waiting = m_valid && m_need && !m_have;
      data_sram_data_ok = ((m_disc > 0) || waiting) && ($urandom_range(0, 4) < 2);
      ws_allowin = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
